z80_bus_ram: RTL and testbench

- Parametrised single-port synchronous RAM with a Z80-style memory-bus front end.
- Decodes its own address window and generates wait states while the read latency elapses.
- Guarantees exactly one RAM write per bus access.
- Sits between the CPU core bus and on-chip block RAM; replaces fixed-size RAM instances.

---
 rtl/z80_bus_ram.sv | 212 +++++++++++++++++++++
 tb/tb_z80_bus_ram.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_bus_ram.sv
// z80_bus_ram -- single-port synchronous RAM behind a Z80-style memory bus.
//
// Purpose:
//   Decodes its own address window (BASE_ADDR, 2^ADDR_W words). Reads hold the
//   CPU with wait_n while the RAM read latency elapses (READ_LAT = 1 or 2).
//   Each write access stores exactly one word, however long the strobe is held.
//
// Optional feature (macro Z80_BUS_RAM_PARITY_EN):
//   Defined   -> RAM is DATA_W+1 wide with an even parity bit per word. par_err
//                is sticky and is cleared by par_clr.
//   Undefined -> par_err is tied to 0 and par_clr is ignored.
//
// Ports:
//   clk      in   system clock, bus inputs sampled on rising edge
//   reset_n  in   asynchronous active-low reset
//   ce       in   block enable, gates the start of new accesses only
//   mreq_n   in   memory request (active low)
//   rd_n     in   read strobe (active low)
//   wr_n     in   write strobe (active low)
//   addr     in   16-bit CPU address
//   din      in   write data
//   dout     out  read data, valid while dout_oe=1
//   dout_oe  out  read data valid / drive enable
//   wait_n   out  wait request to CPU (active low)
//   sel      out  window hit for the current access
//   par_err  out  sticky read parity error
//   par_clr  in   synchronous clear for par_err
module z80_bus_ram #(
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned DATA_W    = 8,
  parameter logic [15:0] BASE_ADDR = 16'h8000,
  parameter int unsigned READ_LAT  = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce,
  input  logic              mreq_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic [15:0]       addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_oe,
  output logic              wait_n,
  output logic              sel,
  output logic              par_err,
  input  logic              par_clr
);

`ifdef Z80_BUS_RAM_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE, HOLD} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              doutOe_q, doutOe_d;
  logic              waitN_q, waitN_d;
  logic              sel_q, sel_d;

  logic [MEM_W-1:0]  mem_q [0:DEPTH-1];
  logic [MEM_W-1:0]  rdStage1_q;
  logic [MEM_W-1:0]  rdStage2_q;
  logic [MEM_W-1:0]  readWord;
  logic [MEM_W-1:0]  ramWdata;
  logic              hit, rdStart, wrStart, ramWe, rdCapture;

  // Window decode; both strobes low together is illegal and starts nothing.
  assign hit     = !mreq_n && (addr[15:ADDR_W] == BASE_ADDR[15:ADDR_W]);
  assign rdStart = hit && ce && !rd_n && wr_n;
  assign wrStart = hit && ce && !wr_n && rd_n;

  // The RAM is written only on the IDLE start edge, so a held wr_n cannot rewrite.
  assign ramWe = (state_q == IDLE) && wrStart;

`ifdef Z80_BUS_RAM_PARITY_EN
  assign ramWdata = {^din, din};
`else
  assign ramWdata = din;
`endif

  // With READ_LAT=2 the extra stage models the RAM output register.
  assign readWord = (READ_LAT == 2) ? rdStage2_q : rdStage1_q;

  // RAM array and read pipeline; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (ramWe) begin
      mem_q[addr[ADDR_W-1:0]] <= ramWdata;
    end
    if (rdCapture) begin
      rdStage1_q <= mem_q[addr[ADDR_W-1:0]];
    end
    if (state_q == RD_WAIT) begin
      rdStage2_q <= rdStage1_q;
    end
  end

  // FSM state and registered bus outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      dout_q   <= '0;
      doutOe_q <= 1'b0;
      waitN_q  <= 1'b1;
      sel_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dout_q   <= dout_d;
      doutOe_q <= doutOe_d;
      waitN_q  <= waitN_d;
      sel_q    <= sel_d;
    end
  end

`ifdef Z80_BUS_RAM_PARITY_EN
  logic parSet;
  logic parErr_q;
`endif

  // Next-state and output decode. Outputs are registered, so dout_oe rises on
  // the edge that leaves RD_DONE and wait_n is low for exactly READ_LAT cycles.
  always_comb begin
    state_d   = state_q;
    dout_d    = dout_q;
    doutOe_d  = doutOe_q;
    waitN_d   = waitN_q;
    sel_d     = sel_q;
    rdCapture = 1'b0;
`ifdef Z80_BUS_RAM_PARITY_EN
    parSet    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        doutOe_d = 1'b0;
        waitN_d  = 1'b1;
        sel_d    = 1'b0;
        if (rdStart) begin
          waitN_d   = 1'b0;
          sel_d     = 1'b1;
          rdCapture = 1'b1;
          state_d   = (READ_LAT == 2) ? RD_WAIT : RD_DONE;
        end else if (wrStart) begin
          sel_d   = 1'b1;
          state_d = HOLD;
        end
      end
      RD_WAIT: begin
        if (mreq_n) begin
          state_d  = IDLE;
          waitN_d  = 1'b1;
          doutOe_d = 1'b0;
          sel_d    = 1'b0;
        end else begin
          waitN_d = 1'b0;
          state_d = RD_DONE;
        end
      end
      RD_DONE: begin
        if (mreq_n) begin
          state_d  = IDLE;
          waitN_d  = 1'b1;
          doutOe_d = 1'b0;
          sel_d    = 1'b0;
        end else begin
          dout_d   = readWord[DATA_W-1:0];
          doutOe_d = 1'b1;
          waitN_d  = 1'b1;
          state_d  = HOLD;
`ifdef Z80_BUS_RAM_PARITY_EN
          parSet   = ^readWord;
`endif
        end
      end
      HOLD: begin
        if (mreq_n || (rd_n && wr_n)) begin
          state_d  = IDLE;
          doutOe_d = 1'b0;
          sel_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef Z80_BUS_RAM_PARITY_EN
  // Sticky parity flag; a new error wins over a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parErr_q <= 1'b0;
    end else if (parSet) begin
      parErr_q <= 1'b1;
    end else if (par_clr) begin
      parErr_q <= 1'b0;
    end
  end
  assign par_err = parErr_q;
`else
  logic unusedParClr;
  assign unusedParClr = par_clr;
  assign par_err      = 1'b0;
`endif

  assign dout    = dout_q;
  assign dout_oe = doutOe_q;
  assign wait_n  = waitN_q;
  assign sel     = sel_q;

endmodule

// File: tb/tb_z80_bus_ram.sv
// tb_z80_bus_ram -- directed bench driving one shared bus into two instances,
// READ_LAT=1 (dut1) and READ_LAT=2 (dut2). Read data is checked through
// per-instance expected-data queues fed from a bench-side memory model.
module tb_z80_bus_ram;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        ce = 1'b1;
  logic        mreq_n = 1'b1;
  logic        rd_n = 1'b1;
  logic        wr_n = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  din = 8'h00;
  logic        par_clr = 1'b0;

  logic [7:0]  dout1, dout2;
  logic        oe1, oe2, wait1, wait2, sel1, sel2, perr1, perr2;

  int nChecks = 0;
  int nErrors = 0;

  logic [7:0] model [0:2047];
  logic [7:0] q1 [$];
  logic [7:0] q2 [$];

  // Free-running clock, 10 time units period.
  always #5 clk = ~clk;

  z80_bus_ram #(.ADDR_W(11), .DATA_W(8), .BASE_ADDR(16'h8000), .READ_LAT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .mreq_n(mreq_n), .rd_n(rd_n),
    .wr_n(wr_n), .addr(addr), .din(din), .dout(dout1), .dout_oe(oe1),
    .wait_n(wait1), .sel(sel1), .par_err(perr1), .par_clr(par_clr)
  );

  z80_bus_ram #(.ADDR_W(11), .DATA_W(8), .BASE_ADDR(16'h8000), .READ_LAT(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .mreq_n(mreq_n), .rd_n(rd_n),
    .wr_n(wr_n), .addr(addr), .din(din), .dout(dout2), .dout_oe(oe2),
    .wait_n(wait2), .sel(sel2), .par_err(perr2), .par_clr(par_clr)
  );

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // One comparison: count it, and report observed/expected on mismatch.
  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive the bus on the falling edge, away from the sampling edge.
  task automatic applyStimulus(input logic m, input logic r, input logic w,
                               input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    mreq_n = m;
    rd_n   = r;
    wr_n   = w;
    addr   = a;
    din    = d;
  endtask

  function automatic logic inWindow(input logic [15:0] a);
    return a[15:11] == 5'b10000;
  endfunction

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_oe1"}, {15'd0, oe1}, 16'd0);
    checkOutput({tag, "_oe2"}, {15'd0, oe2}, 16'd0);
    checkOutput({tag, "_wait1"}, {15'd0, wait1}, 16'd1);
    checkOutput({tag, "_wait2"}, {15'd0, wait2}, 16'd1);
    checkOutput({tag, "_sel1"}, {15'd0, sel1}, 16'd0);
    checkOutput({tag, "_sel2"}, {15'd0, sel2}, 16'd0);
  endtask

  // Write access held for 'hold' cycles; din switches to dLater after the start edge.
  task automatic doWrite(input logic [15:0] a, input logic [7:0] d, input int hold,
                         input logic [7:0] dLater);
    logic expSel;
    expSel = inWindow(a) && ce;
    applyStimulus(1'b0, 1'b1, 1'b0, a, d);
    if (expSel) model[a[10:0]] = d;
    @(posedge clk); #1;
    checkOutput("wr_sel1", {15'd0, sel1}, {15'd0, expSel});
    checkOutput("wr_sel2", {15'd0, sel2}, {15'd0, expSel});
    checkOutput("wr_wait1", {15'd0, wait1}, 16'd1);
    checkOutput("wr_wait2", {15'd0, wait2}, 16'd1);
    din = dLater;
    for (int i = 1; i < hold; i++) @(posedge clk);
    applyStimulus(1'b1, 1'b1, 1'b1, a, dLater);
    @(posedge clk); #1;
    checkIdle("wr_end");
  endtask

  // Read access: exact wait/oe timing per instance, data via the queues.
  task automatic doRead(input logic [15:0] a);
    logic [7:0] e;
    bit got1, got2;
    got1 = 0;
    got2 = 0;
    e = model[a[10:0]];
    q1.push_back(e);
    q2.push_back(e);
    applyStimulus(1'b0, 1'b0, 1'b1, a, 8'h00);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checkOutput("rd_wait1", {15'd0, wait1}, {15'd0, (k >= 1)});
      checkOutput("rd_oe1", {15'd0, oe1}, {15'd0, (k >= 1)});
      checkOutput("rd_wait2", {15'd0, wait2}, {15'd0, (k >= 2)});
      checkOutput("rd_oe2", {15'd0, oe2}, {15'd0, (k >= 2)});
      if (k == 0) begin
        checkOutput("rd_sel1", {15'd0, sel1}, 16'd1);
        checkOutput("rd_sel2", {15'd0, sel2}, 16'd1);
      end
      if (oe1 === 1'b1 && !got1 && q1.size() > 0) begin
        checkOutput("rd_data1", {8'd0, dout1}, {8'd0, q1.pop_front()});
        got1 = 1;
      end
      if (oe2 === 1'b1 && !got2 && q2.size() > 0) begin
        checkOutput("rd_data2", {8'd0, dout2}, {8'd0, q2.pop_front()});
        got2 = 1;
      end
    end
    checkOutput("rd_timeout1", {15'd0, got1}, 16'd1);
    checkOutput("rd_timeout2", {15'd0, got2}, 16'd1);
    q1.delete();
    q2.delete();
    applyStimulus(1'b1, 1'b1, 1'b1, a, 8'h00);
    @(posedge clk); #1;
    checkIdle("rd_end");
    checkOutput("rd_keep1", {8'd0, dout1}, {8'd0, e});
  endtask

  initial begin
    // Reset values while reset is asserted.
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkIdle("reset");
    checkOutput("reset_dout1", {8'd0, dout1}, 16'd0);
    checkOutput("reset_dout2", {8'd0, dout2}, 16'd0);
    checkOutput("reset_perr1", {15'd0, perr1}, 16'd0);
    checkOutput("reset_perr2", {15'd0, perr2}, 16'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);

    // Basic write then read with latency timing on both instances.
    $display("[TB] write/read 8010");
    doWrite(16'h8010, 8'hA5, 1, 8'hA5);
    doRead(16'h8010);

    // Held write strobe with changing din: only the start-edge data lands.
    $display("[TB] single write on held strobe");
    doWrite(16'h8020, 8'h11, 5, 8'h22);
    doRead(16'h8020);

    // Out-of-window accesses must not alias onto the RAM.
    $display("[TB] window boundaries");
    doWrite(16'h87FF, 8'h3C, 1, 8'h3C);
    doWrite(16'h8000, 8'h5A, 1, 8'h5A);
    doWrite(16'h7FFF, 8'hEE, 1, 8'hEE);
    doWrite(16'h8800, 8'hDD, 1, 8'hDD);
    doRead(16'h87FF);
    doRead(16'h8000);

    // ce=0 blocks a new read.
    $display("[TB] ce low");
    ce = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h8010, 8'h00);
    @(posedge clk); #1;
    checkIdle("ce_off");
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h8010, 8'h00);
    ce = 1'b1;
    @(posedge clk);

    // Both strobes low is illegal and must not write.
    $display("[TB] illegal strobes");
    doWrite(16'h8040, 8'h77, 1, 8'h77);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h8040, 8'h99);
    @(posedge clk); #1;
    checkIdle("illegal");
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h8040, 8'h00);
    @(posedge clk);
    doRead(16'h8040);

    // Abort: mreq_n rises right after the start edge.
    $display("[TB] abort");
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h8010, 8'h00);
    @(posedge clk); #1;
    checkOutput("abort_wait1_lo", {15'd0, wait1}, 16'd0);
    checkOutput("abort_wait2_lo", {15'd0, wait2}, 16'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h8010, 8'h00);
    @(posedge clk); #1;
    checkIdle("abort");
    @(posedge clk); #1;
    checkIdle("abort_after");

    // Asynchronous reset while dut2 sits in RD_WAIT.
    $display("[TB] reset mid-read");
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h8010, 8'h00);
    @(posedge clk); #1;
    checkOutput("rst_pre_wait2", {15'd0, wait2}, 16'd0);
    #2 reset_n = 1'b0;
    #1;
    checkIdle("rst_async");
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h8010, 8'h00);
    reset_n = 1'b1;
    @(posedge clk);
    doRead(16'h8010);

`ifdef Z80_BUS_RAM_PARITY_EN
    // Corrupt one stored bit and expect a sticky parity error.
    $display("[TB] parity");
    doWrite(16'h8030, 8'h0F, 1, 8'h0F);
    dut1.mem_q[11'h030] = dut1.mem_q[11'h030] ^ 9'h001;
    dut2.mem_q[11'h030] = dut2.mem_q[11'h030] ^ 9'h001;
    model[11'h030] = 8'h0E;
    doRead(16'h8030);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("par_sticky1", {15'd0, perr1}, 16'd1);
    checkOutput("par_sticky2", {15'd0, perr2}, 16'd1);
    @(negedge clk) par_clr = 1'b1;
    @(negedge clk) par_clr = 1'b0;
    #1;
    checkOutput("par_clr1", {15'd0, perr1}, 16'd0);
    checkOutput("par_clr2", {15'd0, perr2}, 16'd0);
`else
    // Without parity the flag never rises.
    $display("[TB] parity disabled");
    @(negedge clk) par_clr = 1'b1;
    @(negedge clk) par_clr = 1'b0;
    #1;
    checkOutput("par_off1", {15'd0, perr1}, 16'd0);
    checkOutput("par_off2", {15'd0, perr2}, 16'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
